difftest_step_gen: RTL
======================

# difftest_step_gen

Upstream feeder of the simulation endpoint: collects per-cycle commit pulses from the core's commit ports, batches them into the `difftest_step` count the endpoint consumes, and converts the core's trap report into the 64-bit `difftest_exit` code. Guarantees that the step covering the trapping instruction reaches the endpoint before any exit code does, so the final checker step is not lost. All outputs are registered.

## Interface
- `NUM_PORTS`, default 6: number of commit ports.
- `STEP_WIDTH`, default 8: width of `difftest_step`; equals `CONFIG_DIFFTEST_STEPWIDTH`.
- `BATCH`, default 32: pending-count threshold that forces a step. Elaboration error unless `BATCH - 1 + NUM_PORTS <= 2^STEP_WIDTH - 1` and `BATCH >= 1`.
- `FLUSH_TIMEOUT`, default 16: idle cycles with pending commits before a forced flush; 1..255.
- `EXIT_DELAY`, default 4: cycles between the final step and exit presentation; 1..15.
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-low (asserted when 0).
- `commit_valid` in NUM_PORTS: one bit per retired instruction this cycle; any bit pattern is legal.
- `trap_valid` in 1: single-cycle pulse; the trapping instruction is included in this cycle's `commit_valid`.
- `trap_code` in 32: 0 = good trap, nonzero = failure code; sampled with `trap_valid`.
- `difftest_step` out STEP_WIDTH: instructions to check this cycle; 0 = no step.
- `difftest_exit` out 64: 0 = running, all-ones = normal exit, other = abort code.
- `instr_count` out 64: total instructions emitted via `difftest_step` since reset.
- `commit_blocked` out 1: high in DRAIN/EXIT; commits presented then are dropped.

## Operation
- `inc` = popcount(`commit_valid`), 0..NUM_PORTS. `acc` = pending count, width STEP_WIDTH. `sum` = `acc + inc`, never overflows by parameter constraint.
- States: RUN, DRAIN, EXIT.
- RUN, per cycle, priority order:
  - `trap_valid`: `difftest_step <= sum` (may be 0), `acc <= 0`, latch code, load delay counter with EXIT_DELAY, go DRAIN.
  - `sum >= BATCH`: `difftest_step <= sum`, `acc <= 0`, idle counter cleared.
  - `acc > 0`, `inc == 0`, idle counter `== FLUSH_TIMEOUT - 1`: `difftest_step <= acc`, `acc <= 0`, idle counter cleared.
  - Otherwise: `difftest_step <= 0`, `acc <= sum`. Idle counter clears when `inc > 0` or `acc == 0`; it increments when `inc == 0` and `acc > 0`.
- DRAIN: `difftest_step <= 0`; `commit_valid` and `trap_valid` are ignored. The delay counter decrements each cycle. When it reaches 0, go EXIT.
- EXIT: `difftest_exit` = all-ones when the latched code is 0, else `{32'h0000_0001, code}`, so an abort never reads 0 or all-ones. The state is terminal and is left only by reset.
- `instr_count` adds every nonzero `difftest_step` value the cycle it is driven, with 64-bit wrap.
- A second trap while in DRAIN or EXIT is ignored; the first code wins.

## Timing
- Reset (any cycle, including mid-DRAIN): `difftest_step`=0, `difftest_exit`=0, `instr_count`=0, `commit_blocked`=0, `acc`=0, counters=0, state RUN.
- Step latency: a commit in cycle N is reflected in `difftest_step` at cycle N+1 at the earliest, once its batch trigger fires.
- `difftest_step` is nonzero for exactly one cycle per emission; back-to-back emissions are allowed.
- Timeout flush: last commit at cycle N with `acc > 0` → step driven at N+FLUSH_TIMEOUT+1.
- Trap at cycle N: final step at N+1, `commit_blocked`=1 from N+1, `difftest_exit` nonzero from N+1+EXIT_DELAY and held.
- A trap with `sum == 0` still enters DRAIN; the step output stays 0.

## Test plan
- Defaults, 6 commits/cycle for 6 cycles (sum 36 at cycle 5) → `difftest_step`=36 at cycle 6, then 0. Continuing at 6/cycle, the next step is 36 six cycles later; `instr_count` accumulates.
- 3 commits in one cycle then idle → `difftest_step`=3 exactly 17 cycles later, single pulse; `instr_count`=3.
- `trap_valid`, code 0, with 2 commits and acc=5 → `difftest_step`=7 the next cycle; `difftest_exit`=FFFF_FFFF_FFFF_FFFF 4 cycles later; later commits are dropped and `instr_count` stays put.
- Trap with code 0x2A → exit reads 0x0000_0001_0000_002A; a second trap with code 0 in DRAIN changes nothing.
- `reset` low for 1 cycle during DRAIN → all outputs 0 next cycle, state RUN; a new commit stream batches normally.
- Parameters NUM_PORTS=8, STEP_WIDTH=4, BATCH=10 → elaboration error (17 > 15).

Source files
------------

// File: rtl/difftest_step_gen.sv
// Batches per-cycle commit pulses into difftest_step counts and turns the core's
// trap report into the 64-bit difftest_exit code, always emitting the final step first.
module difftest_step_gen #(
    parameter int NUM_PORTS     = 6,
    parameter int STEP_WIDTH    = 8,
    parameter int BATCH         = 32,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int EXIT_DELAY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  commit_valid,
    input  logic                  trap_valid,
    input  logic [31:0]           trap_code,
    output logic [STEP_WIDTH-1:0] difftest_step,
    output logic [63:0]           difftest_exit,
    output logic [63:0]           instr_count,
    output logic                  commit_blocked
);

    generate
        if (BATCH < 1 || (BATCH - 1 + NUM_PORTS) > ((1 << STEP_WIDTH) - 1)) begin : g_bad_batch
            $error("difftest_step_gen: BATCH - 1 + NUM_PORTS must fit in STEP_WIDTH bits and BATCH >= 1");
        end
        if (FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 255) begin : g_bad_timeout
            $error("difftest_step_gen: FLUSH_TIMEOUT must be in 1..255");
        end
        if (EXIT_DELAY < 1 || EXIT_DELAY > 15) begin : g_bad_delay
            $error("difftest_step_gen: EXIT_DELAY must be in 1..15");
        end
    endgenerate

    localparam logic [STEP_WIDTH-1:0] BATCH_W    = STEP_WIDTH'(BATCH);
    localparam logic [7:0]            FLUSH_LAST = 8'(FLUSH_TIMEOUT - 1);
    localparam logic [3:0]            DELAY_W    = 4'(EXIT_DELAY);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXIT  = 2'd2
    } state_t;

    state_t                  state_q,   state_d;
    logic [STEP_WIDTH-1:0]   acc_q,     acc_d;
    logic [7:0]              idle_q,    idle_d;
    logic [3:0]              delay_q,   delay_d;
    logic [31:0]             code_q,    code_d;
    logic [STEP_WIDTH-1:0]   step_q,    step_d;
    logic [63:0]             exit_q,    exit_d;
    logic [63:0]             count_q,   count_d;
    logic                    blocked_q, blocked_d;

    logic [STEP_WIDTH-1:0]   commit_ext [NUM_PORTS];
    logic [STEP_WIDTH-1:0]   inc;
    logic [STEP_WIDTH-1:0]   sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_commit_ext
            assign commit_ext[gi] = STEP_WIDTH'(commit_valid[gi]);
        end
    endgenerate

    // Parameter constraint guarantees acc + inc never overflows STEP_WIDTH.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            inc = inc + commit_ext[i];
        end
        sum = acc_q + inc;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idle_d    = idle_q;
        delay_d   = delay_q;
        code_d    = code_q;
        step_d    = '0;
        exit_d    = exit_q;
        blocked_d = blocked_q;

        case (state_q)
            ST_RUN: begin
                if (trap_valid) begin
                    step_d    = sum;
                    acc_d     = '0;
                    idle_d    = '0;
                    code_d    = trap_code;
                    delay_d   = DELAY_W;
                    blocked_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (sum >= BATCH_W) begin
                    step_d = sum;
                    acc_d  = '0;
                    idle_d = '0;
                end else if (acc_q != '0 && inc == '0 && idle_q == FLUSH_LAST) begin
                    step_d = acc_q;
                    acc_d  = '0;
                    idle_d = '0;
                end else begin
                    acc_d = sum;
                    if (inc != '0 || acc_q == '0) begin
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                delay_d = delay_q - 4'd1;
                if (delay_q == 4'd1) begin
                    state_d = ST_EXIT;
                    // Abort codes carry a 1 in the upper word so they never alias 0 or all-ones.
                    exit_d  = (code_q == 32'd0) ? {64{1'b1}} : {32'h0000_0001, code_q};
                end
            end
            ST_EXIT: begin
                state_d = ST_EXIT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign count_d = count_q + 64'(step_d);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            acc_q     <= '0;
            idle_q    <= '0;
            delay_q   <= '0;
            code_q    <= '0;
            step_q    <= '0;
            exit_q    <= '0;
            count_q   <= '0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idle_q    <= idle_d;
            delay_q   <= delay_d;
            code_q    <= code_d;
            step_q    <= step_d;
            exit_q    <= exit_d;
            count_q   <= count_d;
            blocked_q <= blocked_d;
        end
    end

    assign difftest_step  = step_q;
    assign difftest_exit  = exit_q;
    assign instr_count    = count_q;
    assign commit_blocked = blocked_q;

endmodule
